wb_commit: RTL and testbench
============================

Name: wb_commit

Overview:
Writeback/commit sequencer that drives the register-file write port (W_en, Rd, write data, shift strobe) of the single-issue core. It accepts one retiring instruction per handshake from execute and selects the writeback source: ALU, auipc, link address, or load data. For loads it waits on the data-memory response, then byte-extracts and sign/zero-extends the load data. It emits exactly one commit pulse per accepted instruction, or reports a sticky error.

Parameters:
XLEN, 64, datapath width
MEM_TIMEOUT, 16, max cycles in WAIT_MEM before abort (≥2)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
in_valid  in  1  execute offers retiring instr
in_ready  out  1  wb_commit can accept
in_pc  in  XLEN  instr pc
in_alu_out  in  XLEN  ALU result
in_rd  in  5  destination reg
in_wen  in  1  instr writes rd
in_memtoreg  in  1  instr is load
in_auipc  in  1  auipc
in_jal  in  1  jal
in_jalr  in  1  jalr
in_func3  in  3  load size/sign
in_addr_lo  in  3  load byte offset within doubleword
mem_rvalid  in  1  load data response valid (1-cycle pulse)
mem_rdata  in  XLEN  aligned doubleword
W_en  out  1  register write enable
Rd  out  5  register write index
wr_data  out  XLEN  register write data
shift  out  1  commit strobe, 1 cycle per retired instr
commit_pc  out  XLEN  pc of instr committing this cycle
err_timeout  out  1  sticky: load response timed out
err_stray  out  1  sticky: mem_rvalid outside WAIT_MEM
err_misalign  out  1  sticky: misaligned load offset

Behaviour:
- Decided: one clock clk; reset rst synchronous, active-high.
- Reset: state IDLE. W_en, shift, Rd, wr_data, commit_pc, all err_*, and the timeout counter are 0. An in-flight instruction is dropped with no commit. Reset has priority over all events.
- States: IDLE, WAIT_MEM, COMMIT. in_ready = (state==IDLE)|(state==COMMIT). Accept = in_valid & in_ready.
- Accept of a non-load latches its fields and computes data:
  - auipc: in_alu_out+in_pc
  - jal|jalr: in_pc+4
  - else: in_alu_out
  - Arithmetic is mod 2^XLEN.
  - Next state COMMIT: commit appears the cycle after accept (latency 1).
- Accept of a load: latch fields, clear counter, next state WAIT_MEM.
- WAIT_MEM:
  - mem_rvalid → extract field, go COMMIT next cycle; commit is 1 cycle after rvalid.
  - Otherwise counter+1. When counter reaches MEM_TIMEOUT-1 without rvalid: set err_timeout, go IDLE, no shift, no write.
  - in_ready=0.
- COMMIT (1 cycle): shift=1, commit_pc=latched pc, Rd=latched rd, wr_data=data, W_en = latched wen & (rd!=0). Next state: WAIT_MEM/COMMIT on a new accept, else IDLE. Back-to-back non-loads commit every cycle.
- shift=0 and W_en=0 in every non-COMMIT cycle. Rd/wr_data/commit_pc hold their last values.
- Load extract: offset off = in_addr_lo forced to natural alignment (off & ~(size-1)).
  - func3 000 lb: 8-bit, sign-extend
  - 001 lh: 16-bit, sign-extend
  - 010 lw: 32-bit, sign-extend
  - 011 ld: 64-bit
  - 100 lbu: 8-bit, zero-extend
  - 101 lhu: 16-bit, zero-extend
  - 110 lwu: 32-bit, zero-extend
  - Field = mem_rdata[8*off +: size*8].
  - func3 111: treated as ld, sets err_misalign.
  - Unaligned in_addr_lo sets err_misalign; the write still occurs with the aligned field.
- mem_rvalid in IDLE or COMMIT: ignored, err_stray set.
- mem_rvalid on the exact timeout cycle: the response wins, no timeout.
- err_* clear only on rst.

Test Plan:
- Non-load addi: in_rd=5, in_alu_out=0x2A, in_wen=1, accepted cycle N → cycle N+1: shift=1, W_en=1, Rd=5, wr_data=0x2A. Cycle N+2: shift=0.
- jal: in_pc=0x80000010, rd=1 → wr_data=0x80000014. auipc: alu_out=0x1000, pc=0x80000000 → 0x80001000. Rd=0 → shift=1, W_en=0.
- Loads, mem_rdata=0x8877665544332211, rvalid 3 cycles after accept:
  - lb off=7 → 0xFFFFFFFFFFFFFF88
  - lhu off=6 → 0x8877
  - lw off=4 → 0xFFFFFFFF88776655
  - ld off=0 → full value
  - Commit 1 cycle after rvalid; in_ready=0 while waiting.
- Timeout: load accepted, no rvalid for 16 cycles → err_timeout=1, no shift, back to IDLE, in_ready=1. Next instr commits normally; err_timeout stays 1.
- Back-to-back: 4 non-loads with in_valid held high → 4 consecutive shift pulses with the correct Rd sequence. A stray mem_rvalid during them → err_stray=1 and data unaffected.
- Reset mid-WAIT_MEM: rst pulse, then rvalid → no commit, err_stray=1 (set by the post-reset rvalid), all other outputs at reset values.

Source files
------------

// File: rtl/wb_commit_if.sv
// Execute-to-writeback retire bus, data-memory load response and register-file write port.
// master = execute/memory side driving the retire bus, slave = wb_commit.
interface wb_commit_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_alu_out;
    logic [4:0]      in_rd;
    logic            in_wen;
    logic            in_memtoreg;
    logic            in_auipc;
    logic            in_jal;
    logic            in_jalr;
    logic [2:0]      in_func3;
    logic [2:0]      in_addr_lo;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            W_en;
    logic [4:0]      Rd;
    logic [XLEN-1:0] wr_data;
    logic            shift;
    logic [XLEN-1:0] commit_pc;
    logic            err_timeout;
    logic            err_stray;
    logic            err_misalign;

    modport master (
        output in_valid, in_pc, in_alu_out, in_rd, in_wen, in_memtoreg,
               in_auipc, in_jal, in_jalr, in_func3, in_addr_lo,
               mem_rvalid, mem_rdata,
        input  in_ready, W_en, Rd, wr_data, shift, commit_pc,
               err_timeout, err_stray, err_misalign
    );

    modport slave (
        input  in_valid, in_pc, in_alu_out, in_rd, in_wen, in_memtoreg,
               in_auipc, in_jal, in_jalr, in_func3, in_addr_lo,
               mem_rvalid, mem_rdata,
        output in_ready, W_en, Rd, wr_data, shift, commit_pc,
               err_timeout, err_stray, err_misalign
    );
endinterface

// File: rtl/wb_commit.sv
// Writeback/commit sequencer: picks ALU/auipc/link/load data and strobes one commit per retired instr.
// Latency: non-load commits 1 cycle after accept, load commits 1 cycle after mem_rvalid.
// Backpressure: in_ready low only while waiting on a load response (bounded by MEM_TIMEOUT).
module wb_commit #(
    parameter int XLEN        = 64,
    parameter int MEM_TIMEOUT = 16
) (
    input logic       clk,
    input logic       rst,
    wb_commit_if.slave bus
);
    localparam int CW = $clog2(MEM_TIMEOUT);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_MEM = 2'd1;
    localparam logic [1:0] COMMIT   = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] pc_q;
    logic [4:0]      rd_q;
    logic            wen_q;
    logic [1:0]      lsize_q;
    logic            lunsigned_q;
    logic [2:0]      off_q;

    logic            accept;
    logic [XLEN-1:0] nl_data;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ld_data;
    logic [1:0]      in_size;
    logic [2:0]      in_off;
    logic            in_misalign;

    assign bus.in_ready = (state == IDLE) || (state == COMMIT);

    always_comb begin
        accept = bus.in_valid && bus.in_ready;

        if (bus.in_auipc)
            nl_data = bus.in_alu_out + bus.in_pc;
        else if (bus.in_jal || bus.in_jalr)
            nl_data = bus.in_pc + XLEN'(4);
        else
            nl_data = bus.in_alu_out;

        // func3 111 has no defined load; it is handled as a doubleword load and flagged
        in_size = (bus.in_func3 == 3'b111) ? 2'd3 : bus.in_func3[1:0];
        case (in_size)
            2'd0:    in_off = bus.in_addr_lo;
            2'd1:    in_off = {bus.in_addr_lo[2:1], 1'b0};
            2'd2:    in_off = {bus.in_addr_lo[2], 2'b00};
            default: in_off = 3'b000;
        endcase
        in_misalign = (bus.in_func3 == 3'b111) || (in_off != bus.in_addr_lo);

        shifted = bus.mem_rdata >> {off_q, 3'b000};
        case (lsize_q)
            2'd0:    ld_data = lunsigned_q ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                           : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            2'd1:    ld_data = lunsigned_q ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                           : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            2'd2:    ld_data = lunsigned_q ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                           : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            default: ld_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            pc_q             <= '0;
            rd_q             <= '0;
            wen_q            <= 1'b0;
            lsize_q          <= '0;
            lunsigned_q      <= 1'b0;
            off_q            <= '0;
            bus.W_en         <= 1'b0;
            bus.shift        <= 1'b0;
            bus.Rd           <= '0;
            bus.wr_data      <= '0;
            bus.commit_pc    <= '0;
            bus.err_timeout  <= 1'b0;
            bus.err_stray    <= 1'b0;
            bus.err_misalign <= 1'b0;
        end else begin
            bus.shift <= 1'b0;
            bus.W_en  <= 1'b0;
            if (bus.mem_rvalid && state != WAIT_MEM)
                bus.err_stray <= 1'b1;

            case (state)
                IDLE, COMMIT: begin
                    if (accept && bus.in_memtoreg) begin
                        pc_q        <= bus.in_pc;
                        rd_q        <= bus.in_rd;
                        wen_q       <= bus.in_wen;
                        lsize_q     <= in_size;
                        lunsigned_q <= bus.in_func3[2] && (bus.in_func3 != 3'b111);
                        off_q       <= in_off;
                        cnt         <= '0;
                        if (in_misalign)
                            bus.err_misalign <= 1'b1;
                        state <= WAIT_MEM;
                    end else if (accept) begin
                        bus.shift     <= 1'b1;
                        bus.W_en      <= bus.in_wen && (bus.in_rd != 5'd0);
                        bus.Rd        <= bus.in_rd;
                        bus.wr_data   <= nl_data;
                        bus.commit_pc <= bus.in_pc;
                        state         <= COMMIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_MEM: begin
                    // a response on the final allowed cycle still wins over the timeout
                    if (bus.mem_rvalid) begin
                        bus.shift     <= 1'b1;
                        bus.W_en      <= wen_q && (rd_q != 5'd0);
                        bus.Rd        <= rd_q;
                        bus.wr_data   <= ld_data;
                        bus.commit_pc <= pc_q;
                        state         <= COMMIT;
                    end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
                        bus.err_timeout <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: non-load sources, load extraction, timeout, back-to-back and reset.
module tb_wb_commit;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    localparam logic [63:0] MEMVAL = 64'h8877665544332211;

    always #5 clk = ~clk;

    wb_commit_if #(.XLEN(64)) bus();

    wb_commit #(.XLEN(64), .MEM_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] exp;
        logic [4:0]  rd;
        logic        wen;
        logic        au;
        logic        jl;
        logic        jr;
        logic        exp_w;
    } nl_vec_t;

    typedef struct {
        logic [2:0]  func3;
        logic [2:0]  off;
        logic [63:0] exp;
        logic        mis;
    } ld_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nl(input logic [63:0] pc, input logic [63:0] alu, input logic [4:0] rd,
                            input logic wen, input logic au, input logic jl, input logic jr);
        bus.in_valid    = 1'b1;
        bus.in_pc       = pc;
        bus.in_alu_out  = alu;
        bus.in_rd       = rd;
        bus.in_wen      = wen;
        bus.in_memtoreg = 1'b0;
        bus.in_auipc    = au;
        bus.in_jal      = jl;
        bus.in_jalr     = jr;
        bus.in_func3    = 3'b000;
        bus.in_addr_lo  = 3'b000;
    endtask

    task automatic drive_ld(input logic [63:0] pc, input logic [2:0] func3, input logic [2:0] off,
                            input logic [4:0] rd);
        bus.in_valid    = 1'b1;
        bus.in_pc       = pc;
        bus.in_alu_out  = 64'hDEAD_BEEF_0000_0000;
        bus.in_rd       = rd;
        bus.in_wen      = 1'b1;
        bus.in_memtoreg = 1'b1;
        bus.in_auipc    = 1'b0;
        bus.in_jal      = 1'b0;
        bus.in_jalr     = 1'b0;
        bus.in_func3    = func3;
        bus.in_addr_lo  = off;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (bus.shift !== 1'b0) begin bad++; $display("FAIL reset_shift: got %b want 0", bus.shift); end
        total++; if (bus.W_en !== 1'b0) begin bad++; $display("FAIL reset_wen: got %b want 0", bus.W_en); end
        total++; if (bus.Rd !== 5'd0) begin bad++; $display("FAIL reset_rd: got %0d want 0", bus.Rd); end
        total++; if (bus.wr_data !== 64'd0) begin bad++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data); end
        total++; if (bus.commit_pc !== 64'd0) begin bad++; $display("FAIL reset_commit_pc: got %h want 0", bus.commit_pc); end
        total++; if ({bus.err_timeout, bus.err_stray, bus.err_misalign} !== 3'b000) begin
            bad++; $display("FAIL reset_err: got %b want 000", {bus.err_timeout, bus.err_stray, bus.err_misalign}); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_nonload();
        nl_vec_t v[7];
        v[0] = '{64'h100,      64'h2A,                64'h2A,         5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        v[1] = '{64'h80000010, 64'hDEAD,              64'h80000014,   5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        v[2] = '{64'h2000,     64'h5555,              64'h2004,       5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        v[3] = '{64'h80000000, 64'h1000,              64'h80001000,   5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        v[4] = '{64'h40,       64'h77,                64'h77,         5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        v[5] = '{64'h20,       64'hFFFFFFFFFFFFFFF0,  64'h10,         5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        v[6] = '{64'h30,       64'h99,                64'h99,         5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive_nl(v[i].pc, v[i].alu, v[i].rd, v[i].wen, v[i].au, v[i].jl, v[i].jr);
            tick();
            bus.in_valid = 1'b0;
            total++; if (bus.shift !== 1'b1) begin bad++; $display("FAIL nl_shift[%0d]: got %b want 1", i, bus.shift); end
            total++; if (bus.W_en !== v[i].exp_w) begin bad++; $display("FAIL nl_wen[%0d]: got %b want %b", i, bus.W_en, v[i].exp_w); end
            total++; if (bus.Rd !== v[i].rd) begin bad++; $display("FAIL nl_rd[%0d]: got %0d want %0d", i, bus.Rd, v[i].rd); end
            total++; if (bus.wr_data !== v[i].exp) begin bad++; $display("FAIL nl_data[%0d]: got %h want %h", i, bus.wr_data, v[i].exp); end
            total++; if (bus.commit_pc !== v[i].pc) begin bad++; $display("FAIL nl_pc[%0d]: got %h want %h", i, bus.commit_pc, v[i].pc); end
            tick();
            total++; if ({bus.shift, bus.W_en} !== 2'b00) begin bad++; $display("FAIL nl_idle_strobes[%0d]: got %b want 00", i, {bus.shift, bus.W_en}); end
            total++; if (bus.Rd !== v[i].rd) begin bad++; $display("FAIL nl_rd_hold[%0d]: got %0d want %0d", i, bus.Rd, v[i].rd); end
        end
    endtask

    task automatic test_loads();
        ld_vec_t v[9];
        v[0] = '{3'b000, 3'd7, 64'hFFFFFFFFFFFFFF88, 1'b0};
        v[1] = '{3'b101, 3'd6, 64'h0000000000008877, 1'b0};
        v[2] = '{3'b010, 3'd4, 64'hFFFFFFFF88776655, 1'b0};
        v[3] = '{3'b011, 3'd0, MEMVAL,               1'b0};
        v[4] = '{3'b100, 3'd0, 64'h0000000000000011, 1'b0};
        v[5] = '{3'b001, 3'd2, 64'h0000000000004433, 1'b0};
        v[6] = '{3'b110, 3'd4, 64'h0000000088776655, 1'b0};
        v[7] = '{3'b101, 3'd7, 64'h0000000000008877, 1'b1};
        v[8] = '{3'b111, 3'd3, MEMVAL,               1'b1};
        bus.mem_rdata = MEMVAL;
        for (int i = 0; i < 9; i++) begin
            drive_ld(64'h3000 + 64'(i * 4), v[i].func3, v[i].off, 5'(10 + i));
            tick();
            bus.in_valid = 1'b0;
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL ld_wait_ready[%0d]: got %b want 0", i, bus.in_ready); end
            tick();
            tick();
            bus.mem_rvalid = 1'b1;
            total++; if (bus.shift !== 1'b0) begin bad++; $display("FAIL ld_early_shift[%0d]: got %b want 0", i, bus.shift); end
            tick();
            bus.mem_rvalid = 1'b0;
            total++; if ({bus.shift, bus.W_en} !== 2'b11) begin bad++; $display("FAIL ld_commit[%0d]: got %b want 11", i, {bus.shift, bus.W_en}); end
            total++; if (bus.Rd !== 5'(10 + i)) begin bad++; $display("FAIL ld_rd[%0d]: got %0d want %0d", i, bus.Rd, 10 + i); end
            total++; if (bus.wr_data !== v[i].exp) begin bad++; $display("FAIL ld_data[%0d]: got %h want %h", i, bus.wr_data, v[i].exp); end
            total++; if (bus.commit_pc !== 64'h3000 + 64'(i * 4)) begin bad++; $display("FAIL ld_pc[%0d]: got %h want %h", i, bus.commit_pc, 64'h3000 + 64'(i * 4)); end
            total++; if (bus.err_misalign !== v[i].mis) begin bad++; $display("FAIL ld_misalign[%0d]: got %b want %b", i, bus.err_misalign, v[i].mis); end
            tick();
        end
    endtask

    task automatic test_rvalid_at_timeout();
        drive_ld(64'h4000, 3'b011, 3'd0, 5'd12);
        tick();
        bus.in_valid = 1'b0;
        repeat (15) tick();
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        total++; if (bus.shift !== 1'b1) begin bad++; $display("FAIL edge_shift: got %b want 1", bus.shift); end
        total++; if (bus.wr_data !== MEMVAL) begin bad++; $display("FAIL edge_data: got %h want %h", bus.wr_data, MEMVAL); end
        total++; if (bus.err_timeout !== 1'b0) begin bad++; $display("FAIL edge_timeout: got %b want 0", bus.err_timeout); end
        tick();
    endtask

    task automatic test_timeout();
        logic saw_shift;
        saw_shift = 1'b0;
        drive_ld(64'h5000, 3'b010, 3'd0, 5'd13);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            saw_shift = saw_shift | bus.shift;
        end
        total++; if ({bus.err_timeout, bus.in_ready} !== 2'b00) begin bad++; $display("FAIL to_before: got %b want 00", {bus.err_timeout, bus.in_ready}); end
        tick();
        saw_shift = saw_shift | bus.shift;
        total++; if (bus.err_timeout !== 1'b1) begin bad++; $display("FAIL to_flag: got %b want 1", bus.err_timeout); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL to_ready: got %b want 1", bus.in_ready); end
        total++; if ({saw_shift, bus.W_en} !== 2'b00) begin bad++; $display("FAIL to_no_commit: got %b want 00", {saw_shift, bus.W_en}); end
        drive_nl(64'h6000, 64'h55, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        total++; if ({bus.shift, bus.W_en} !== 2'b11) begin bad++; $display("FAIL to_next_commit: got %b want 11", {bus.shift, bus.W_en}); end
        total++; if (bus.wr_data !== 64'h55) begin bad++; $display("FAIL to_next_data: got %h want 55", bus.wr_data); end
        total++; if (bus.err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", bus.err_timeout); end
        tick();
    endtask

    task automatic test_back_to_back();
        total++; if (bus.err_stray !== 1'b0) begin bad++; $display("FAIL b2b_stray_before: got %b want 0", bus.err_stray); end
        for (int i = 0; i < 4; i++) begin
            drive_nl(64'h7000 + 64'(i * 4), 64'h100 + 64'(i), 5'(20 + i), 1'b1, 1'b0, 1'b0, 1'b0);
            bus.mem_rvalid = (i == 1);
            tick();
            total++; if (bus.shift !== 1'b1) begin bad++; $display("FAIL b2b_shift[%0d]: got %b want 1", i, bus.shift); end
            total++; if (bus.Rd !== 5'(20 + i)) begin bad++; $display("FAIL b2b_rd[%0d]: got %0d want %0d", i, bus.Rd, 20 + i); end
            total++; if (bus.wr_data !== 64'h100 + 64'(i)) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, bus.wr_data, 64'h100 + 64'(i)); end
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.in_ready); end
        end
        bus.in_valid   = 1'b0;
        bus.mem_rvalid = 1'b0;
        tick();
        total++; if (bus.shift !== 1'b0) begin bad++; $display("FAIL b2b_end_shift: got %b want 0", bus.shift); end
        total++; if (bus.err_stray !== 1'b1) begin bad++; $display("FAIL b2b_stray: got %b want 1", bus.err_stray); end
    endtask

    task automatic test_reset_midload();
        drive_ld(64'h8000, 3'b111, 3'd0, 5'd15);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({bus.err_timeout, bus.err_stray, bus.err_misalign} !== 3'b000) begin
            bad++; $display("FAIL rst_err_clear: got %b want 000", {bus.err_timeout, bus.err_stray, bus.err_misalign}); end
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        total++; if ({bus.shift, bus.W_en} !== 2'b00) begin bad++; $display("FAIL rst_no_commit: got %b want 00", {bus.shift, bus.W_en}); end
        total++; if (bus.Rd !== 5'd0) begin bad++; $display("FAIL rst_rd: got %0d want 0", bus.Rd); end
        total++; if (bus.wr_data !== 64'd0) begin bad++; $display("FAIL rst_data: got %h want 0", bus.wr_data); end
        total++; if (bus.commit_pc !== 64'd0) begin bad++; $display("FAIL rst_pc: got %h want 0", bus.commit_pc); end
        total++; if ({bus.err_timeout, bus.err_stray, bus.err_misalign} !== 3'b010) begin
            bad++; $display("FAIL rst_err_after: got %b want 010", {bus.err_timeout, bus.err_stray, bus.err_misalign}); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.in_ready); end
        tick();
        total++; if (bus.shift !== 1'b0) begin bad++; $display("FAIL rst_late_shift: got %b want 0", bus.shift); end
    endtask

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_pc       = '0;
        bus.in_alu_out  = '0;
        bus.in_rd       = '0;
        bus.in_wen      = 1'b0;
        bus.in_memtoreg = 1'b0;
        bus.in_auipc    = 1'b0;
        bus.in_jal      = 1'b0;
        bus.in_jalr     = 1'b0;
        bus.in_func3    = '0;
        bus.in_addr_lo  = '0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        test_reset();
        test_nonload();
        test_loads();
        test_rvalid_at_timeout();
        test_timeout();
        test_back_to_back();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
